// File: rtl/wb_rr_arbiter_wd.sv
// Round-robin Wishbone bus arbiter with lock support and a per-grant watchdog
// that revokes the bus from a master whose cycle is never terminated.
module wb_rr_arbiter_wd #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 256,
    parameter int unsigned ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_cyc,
    input  logic [NUM_MASTERS-1:0] m_lock,
    input  logic                   s_ack,
    input  logic                   s_err,
    input  logic                   s_rty,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   gnt_valid,
    output logic                   timeout_err,
    output logic [ID_W-1:0]        timeout_id
);

    localparam int unsigned WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [ID_W-1:0]        LAST_IDX = ID_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_MASTERS-1:0] mask;
    logic [NUM_MASTERS-1:0] mask_nxt;
    logic [ID_W-1:0]        last_owner;
    logic [ID_W-1:0]        last_nxt;
    logic [WD_W-1:0]        wd_cnt;
    logic [WD_W-1:0]        wd_nxt;
    logic [NUM_MASTERS-1:0] gnt_nxt;
    logic [ID_W-1:0]        gnt_id_nxt;
    logic                   gnt_valid_nxt;
    logic                   timeout_err_nxt;
    logic [ID_W-1:0]        timeout_id_nxt;

    logic [NUM_MASTERS-1:0] elig;
    logic                   term;
    logic                   hold;
    logic                   wd_fire;
    logic [ID_W-1:0]        base;
    logic [ID_W-1:0]        pick;

    // First requester after 'from', wrapping; 'from' itself is examined last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                input logic [ID_W-1:0]        from);
        logic [ID_W-1:0] sel;
        int unsigned     idx;
        sel = from;
        for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
            idx = (32'(from) + k) % NUM_MASTERS;
            if (req[ID_W'(idx)]) begin
                sel = ID_W'(idx);
            end
        end
        return sel;
    endfunction

    assign elig    = m_cyc & ~mask;
    assign term    = s_ack | s_err | s_rty;
    assign hold    = m_cyc[gnt_id] | m_lock[gnt_id];
    assign wd_fire = (TIMEOUT != 0) && m_cyc[gnt_id] && !term &&
                     (wd_cnt == WD_W'(WD_LAST));
    assign base    = (state == S_GRANT) ? gnt_id : last_owner;
    assign pick    = rr_pick(elig, base);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_valid   <= 1'b0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
            wd_cnt      <= '0;
            mask        <= '0;
            last_owner  <= LAST_IDX;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            gnt_id      <= gnt_id_nxt;
            gnt_valid   <= gnt_valid_nxt;
            timeout_err <= timeout_err_nxt;
            timeout_id  <= timeout_id_nxt;
            wd_cnt      <= wd_nxt;
            mask        <= mask_nxt;
            last_owner  <= last_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ABORT: begin
                state_nxt = (elig != '0) ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (!hold) begin
                    state_nxt = (elig != '0) ? S_GRANT : S_IDLE;
                end else if (wd_fire) begin
                    state_nxt = S_ABORT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, watchdog, mask and last-owner next values
    always_comb begin
        gnt_nxt         = '0;
        gnt_id_nxt      = gnt_id;
        gnt_valid_nxt   = 1'b0;
        timeout_err_nxt = 1'b0;
        timeout_id_nxt  = timeout_id;
        wd_nxt          = '0;
        mask_nxt        = mask & m_cyc;
        last_nxt        = last_owner;

        if (state == S_GRANT) begin
            if (!hold) begin
                last_nxt = gnt_id;
            end else if (wd_fire) begin
                last_nxt           = gnt_id;
                timeout_err_nxt    = 1'b1;
                timeout_id_nxt     = gnt_id;
                mask_nxt[gnt_id]   = 1'b1;
            end else if (!term && m_cyc[gnt_id] && (TIMEOUT != 0)) begin
                wd_nxt = wd_cnt + WD_W'(1);
            end
        end

        if (state_nxt == S_GRANT) begin
            gnt_valid_nxt = 1'b1;
            if (state != S_GRANT || !hold) begin
                gnt_nxt    = ONE << pick;
                gnt_id_nxt = pick;
                wd_nxt     = '0;
            end else begin
                gnt_nxt = gnt;
            end
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_wd.sv
// Table-driven bench for wb_rr_arbiter_wd (4 masters, 8-cycle watchdog);
// each row is one clock of stimulus plus the outputs expected after that edge.
module tb_wb_rr_arbiter_wd;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 8;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   m_cyc;
    logic [N-1:0]   m_lock;
    logic           s_ack;
    logic           s_err;
    logic           s_rty;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout_err;
    logic [IDW-1:0] timeout_id;

    wb_rr_arbiter_wd #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TMO),
        .ID_W        (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_cyc       (m_cyc),
        .m_lock      (m_lock),
        .s_ack       (s_ack),
        .s_err       (s_err),
        .s_rty       (s_rty),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic           rst;
        logic [N-1:0]   cyc;
        logic [N-1:0]   lock;
        logic           ack;
        logic           err;
        logic           rty;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           valid;
        logic           terr;
        logic [IDW-1:0] tid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input string tag, input logic r,
                                input logic [N-1:0] c, input logic [N-1:0] l,
                                input logic a, input logic e, input logic y,
                                input logic [N-1:0] g, input logic [IDW-1:0] id,
                                input logic te, input logic [IDW-1:0] tid);
        vec_t v;
        v.tag = tag; v.rst = r; v.cyc = c; v.lock = l;
        v.ack = a; v.err = e; v.rty = y;
        v.gnt = g; v.id = id; v.valid = (g != '0); v.terr = te; v.tid = tid;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string what, input int row, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", what, row, act, want);
        end
    endtask

    task automatic compare_row(input int row);
        vec_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".gnt"},         row, 32'(gnt),         32'(e.gnt));
        chk({e.tag, ".gnt_valid"},   row, 32'(gnt_valid),   32'(e.valid));
        if (e.valid) begin
            chk({e.tag, ".gnt_id"},  row, 32'(gnt_id),      32'(e.id));
        end
        chk({e.tag, ".timeout_err"}, row, 32'(timeout_err), 32'(e.terr));
        chk({e.tag, ".timeout_id"},  row, 32'(timeout_id),  32'(e.tid));
        chk({e.tag, ".onehot0"},     row, 32'($onehot0(gnt)), 32'(1));
        chk({e.tag, ".valid_eq_or"}, row, 32'(gnt_valid),   32'(|gnt));
    endtask

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] oh_next;

        rst = 1'b1; m_cyc = '0; m_lock = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

        // A: grant latency, direct hand-over, release to idle
        add("a_rst",   1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("a_gnt1",  0, 4'b0110, 4'b0000, 0, 0, 0, 4'b0010, 1, 0, 0);
        add("a_hold",  0, 4'b0110, 4'b0000, 1, 0, 0, 4'b0010, 1, 0, 0);
        add("a_hold",  0, 4'b0110, 4'b0000, 0, 0, 1, 4'b0010, 1, 0, 0);
        add("a_hold",  0, 4'b0110, 4'b0000, 0, 0, 0, 4'b0010, 1, 0, 0);
        add("a_hand",  0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 0);
        add("a_hold2", 0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 2, 0, 0);
        add("a_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("a_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

        // B: full rotation 0,1,2,3,0 with every master requesting
        add("b_rst",   1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("b_g0",    0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 0);
        for (int m = 0; m < 4; m++) begin
            oh      = 4'(1 << m);
            oh_next = 4'(1 << ((m + 1) % 4));
            for (int k = 0; k < 3; k++) begin
                add("b_ack", 0, 4'b1111, 4'b0000, 1, 0, 0, oh, IDW'(m), 0, 0);
            end
            add("b_rot", 0, 4'b1111 & ~oh, 4'b0000, 0, 0, 0, oh_next, IDW'((m + 1) % 4), 0, 0);
        end
        add("b_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

        // C: lock holds the bus with cyc low
        add("c_g1",    0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 0, 0);
        add("c_hold",  0, 4'b1010, 4'b0010, 1, 0, 0, 4'b0010, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add("c_lock", 0, 4'b1000, 4'b0010, 0, 0, 0, 4'b0010, 1, 0, 0);
        end
        add("c_rel",   0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 0);
        add("c_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

        // D: watchdog revokes master 2, which stays masked until it drops cyc
        add("d_g2",    0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 0);
        for (int k = 0; k < 7; k++) begin
            add("d_wait", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 0);
        end
        add("d_tmo",   0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 2);
        for (int k = 0; k < 3; k++) begin
            add("d_mask", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);
        end
        add("d_drop",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);
        add("d_regnt", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 2);
        add("d_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);

        // E: termination in the last watchdog cycle wins; counter restarts
        add("e_g2",    0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 2);
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 7; k++) begin
                add("e_wait", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 2);
            end
            add("e_term", 0, 4'b0100, 4'b0000, t == 0, t == 1, t == 2, 4'b0100, 2, 0, 2);
        end
        for (int k = 0; k < 7; k++) begin
            add("e_wait", 0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 2, 0, 2);
        end
        add("e_tmo",   0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 2);
        add("e_drop",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);

        // F: reset mid-grant, then master 0 has top priority
        add("f_g3",    0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 2);
        for (int k = 0; k < 5; k++) begin
            add("f_wait", 0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 2);
        end
        add("f_rst",   1, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("f_g0",    0, 4'b1001, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 0);
        add("f_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

        // G: abort hands straight to another requester; masked lock is ignored
        add("g_g3",    0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 0);
        for (int k = 0; k < 7; k++) begin
            add("g_wait", 0, 4'b1010, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 0);
        end
        add("g_tmo",   0, 4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 3);
        add("g_hand",  0, 4'b1010, 4'b1000, 0, 0, 0, 4'b0010, 1, 0, 3);
        add("g_lkmsk", 0, 4'b1000, 4'b1000, 0, 0, 0, 4'b0000, 0, 0, 3);
        add("g_masked",0, 4'b1000, 4'b1000, 0, 0, 0, 4'b0000, 0, 0, 3);
        add("g_clear", 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 3);
        add("g_regnt", 0, 4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 3, 0, 3);
        add("g_end",   0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            m_cyc  = vecs[i].cyc;
            m_lock = vecs[i].lock;
            s_ack  = vecs[i].ack;
            s_err  = vecs[i].err;
            s_rty  = vecs[i].rty;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            compare_row(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
